// File: rtl/pong_match_if.sv
// ============================================================================
//  Module      : pong_match_if
//  Description : Control/status bundle between the frame-timing/button logic
//                and the pong match sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pong_match_if;
   logic       frame_tick;
   logic       start_btn;
   logic       serve_btn;
   logic       miss_top;
   logic       miss_bot;
   logic       logo_en;
   logic       ball_run;
   logic       serve_pulse;
   logic       serve_dir;
   logic [7:0] p1_score;
   logic [7:0] p2_score;
   logic [1:0] winner;
   logic [2:0] state_o;

   // Master drives events and observes status; slave is the sequencer.
   modport master (
      output frame_tick, start_btn, serve_btn, miss_top, miss_bot,
      input  logo_en, ball_run, serve_pulse, serve_dir,
             p1_score, p2_score, winner, state_o
   );

   modport slave (
      input  frame_tick, start_btn, serve_btn, miss_top, miss_bot,
      output logo_en, ball_run, serve_pulse, serve_dir,
             p1_score, p2_score, winner, state_o
   );
endinterface

`default_nettype wire

// File: rtl/pong_match_ctrl.sv
// ============================================================================
//  Module      : pong_match_ctrl
//  Description : Game-flow sequencer: serve/rally/point/over control, scores
//                and winner detection, all timing counted in frames.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_match_ctrl #(
   parameter int WIN_SCORE     = 11,
   parameter int PAUSE_FRAMES  = 60,
   parameter int SERVE_TIMEOUT = 180
) (
   input  wire logic    pixel_clk,
   input  wire logic    rst_n,
   pong_match_if.slave  bus
);

   localparam int CNT_MAX = (PAUSE_FRAMES > SERVE_TIMEOUT) ? PAUSE_FRAMES : SERVE_TIMEOUT;
   localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 8) ? $clog2(CNT_MAX + 1) : 8;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SERVE = 3'd1;
   localparam logic [2:0] ST_RALLY = 3'd2;
   localparam logic [2:0] ST_POINT = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   localparam logic [CNT_W-1:0] C_PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST    = CNT_W'((SERVE_TIMEOUT == 0) ? 0 : SERVE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_CNT_SAT    = {CNT_W{1'b1}};
   localparam logic [7:0]       C_WIN        = 8'(WIN_SCORE);
   localparam bit               C_AUTO_EN    = (SERVE_TIMEOUT != 0);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       p1_q, p1_d;
   logic [7:0]       p2_q, p2_d;
   logic [1:0]       winner_q, winner_d;
   logic             dir_q, dir_d;
   logic             pulse_q, pulse_d;
   logic             start_btn_q;
   logic             serve_btn_q;

   logic w_start_rise;
   logic w_serve_rise;
   logic w_auto_serve;
   logic w_serve_go;
   logic w_win_p1;
   logic w_win_p2;
   logic w_pause_done;

   assign w_start_rise = bus.start_btn & ~start_btn_q;
   assign w_serve_rise = bus.serve_btn & ~serve_btn_q;
   assign w_auto_serve = C_AUTO_EN & bus.frame_tick & (cnt_q == C_TO_LAST);
   assign w_serve_go   = w_serve_rise | w_auto_serve;
   assign w_win_p1     = (p1_q == C_WIN);
   assign w_win_p2     = (p2_q == C_WIN);
   assign w_pause_done = bus.frame_tick & (cnt_q == C_PAUSE_LAST);

   // State and datapath registers; button history resets high so a button
   // held through reset produces no edge.
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         p1_q        <= '0;
         p2_q        <= '0;
         winner_q    <= 2'b00;
         dir_q       <= 1'b0;
         pulse_q     <= 1'b0;
         start_btn_q <= 1'b1;
         serve_btn_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p1_q        <= p1_d;
         p2_q        <= p2_d;
         winner_q    <= winner_d;
         dir_q       <= dir_d;
         pulse_q     <= pulse_d;
         start_btn_q <= bus.start_btn;
         serve_btn_q <= bus.serve_btn;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (w_start_rise) state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (w_serve_go) state_d = ST_RALLY;
         end
         ST_RALLY: begin
            if (bus.miss_top || bus.miss_bot) state_d = ST_POINT;
         end
         ST_POINT: begin
            if (w_win_p1 || w_win_p2) state_d = ST_OVER;
            else if (w_pause_done)    state_d = ST_SERVE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      pulse_d  = (state_q == ST_SERVE) && (state_d == ST_RALLY);

      // A tick on a transition cycle is not credited to the new state.
      if (state_d != state_q)
         cnt_d = '0;
      else if (bus.frame_tick && (cnt_q != C_CNT_SAT))
         cnt_d = cnt_q + 1'b1;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (w_start_rise) begin
               p1_d     = '0;
               p2_d     = '0;
               winner_d = 2'b00;
               dir_d    = 1'b0;
            end
         end
         ST_RALLY: begin
            if (bus.miss_top && !bus.miss_bot) begin
               if (p2_q != C_WIN) p2_d = p2_q + 8'd1;
               dir_d = 1'b1;
            end else if (bus.miss_bot && !bus.miss_top) begin
               if (p1_q != C_WIN) p1_d = p1_q + 8'd1;
               dir_d = 1'b0;
            end
         end
         ST_POINT: begin
            if (w_win_p1)      winner_d = 2'b01;
            else if (w_win_p2) winner_d = 2'b10;
         end
         default: ;
      endcase
   end

   assign bus.state_o     = state_q;
   assign bus.logo_en     = (state_q == ST_IDLE);
   assign bus.ball_run    = (state_q == ST_RALLY);
   assign bus.serve_pulse = pulse_q;
   assign bus.serve_dir   = dir_q;
   assign bus.p1_score    = p1_q;
   assign bus.p2_score    = p2_q;
   assign bus.winner      = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
// ============================================================================
//  Module      : tb_pong_match_ctrl
//  Description : Randomized scoreboard bench for pong_match_ctrl against a
//                procedural game-rules model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pong_match_ctrl;

   localparam int WIN = 3;
   localparam int PF  = 8;
   localparam int TO  = 5;
   localparam int N_RANDOM = 8000;

   logic pixel_clk = 1'b0;
   logic rst_n     = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   pong_match_if bus ();

   pong_match_ctrl #(
      .WIN_SCORE     (WIN),
      .PAUSE_FRAMES  (PF),
      .SERVE_TIMEOUT (TO)
   ) dut (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   typedef struct {
      int logo; int run; int pulse; int dir;
      int p1;   int p2;  int win;   int st;
   } exp_t;

   exp_t exp_q[$];
   int   total   = 0;
   int   bad     = 0;
   bit   started = 1'b0;

   // Game-rules model: 0 idle, 1 serve, 2 rally, 3 point, 4 over.
   int m_st, m_cnt, m_p1, m_p2, m_win, m_dir, m_pulse, m_pst, m_psv;

   function automatic void model_step(input bit r_n, input bit fr, input bit st,
                                      input bit sv, input bit mt, input bit mb);
      bit st_rise, sv_rise;
      int nxt;
      if (!r_n) begin
         m_st = 0; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0;
         m_pulse = 0; m_pst = 1; m_psv = 1;
         return;
      end
      st_rise = st && (m_pst == 0);
      sv_rise = sv && (m_psv == 0);
      m_pst = int'(st); m_psv = int'(sv);
      m_pulse = 0;
      nxt = m_st;
      if (m_st == 0 || m_st == 4) begin
         if (st_rise) begin
            m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; nxt = 1;
         end
      end else if (m_st == 1) begin
         if (sv_rise || (fr && m_cnt == TO - 1)) begin
            nxt = 2; m_pulse = 1;
         end else if (fr) m_cnt++;
      end else if (m_st == 2) begin
         if (mt || mb) begin
            nxt = 3;
            if (mt && !mb) begin m_p2 = (m_p2 < WIN) ? m_p2 + 1 : m_p2; m_dir = 1; end
            if (mb && !mt) begin m_p1 = (m_p1 < WIN) ? m_p1 + 1 : m_p1; m_dir = 0; end
         end
      end else begin
         if (m_p1 == WIN)      begin m_win = 1; nxt = 4; end
         else if (m_p2 == WIN) begin m_win = 2; nxt = 4; end
         else if (fr) begin
            if (m_cnt == PF - 1) nxt = 1;
            else m_cnt++;
         end
      end
      if (nxt != m_st) m_cnt = 0;
      m_st = nxt;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.logo = (m_st == 0) ? 1 : 0;
      e.run  = (m_st == 2) ? 1 : 0;
      e.pulse = m_pulse; e.dir = m_dir;
      e.p1 = m_p1; e.p2 = m_p2; e.win = m_win; e.st = m_st;
      return e;
   endfunction

   task automatic drive(input bit r_n, input bit fr, input bit st,
                        input bit sv, input bit mt, input bit mb);
      @(negedge pixel_clk);
      rst_n          = r_n;
      bus.frame_tick = fr;
      bus.start_btn  = st;
      bus.serve_btn  = sv;
      bus.miss_top   = mt;
      bus.miss_bot   = mb;
      model_step(r_n, fr, st, sv, mt, mb);
      exp_q.push_back(model_out());
      started = 1'b1;
   endtask

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endfunction

   // Monitor: outputs are registered, so every cycle presents a response.
   initial begin
      exp_t e;
      forever begin
         @(posedge pixel_clk);
         #1;
         if (started) begin
            if (exp_q.size() == 0) begin
               chk("queue_underflow", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("state_o",     int'(bus.state_o),     e.st);
               chk("logo_en",     int'(bus.logo_en),     e.logo);
               chk("ball_run",    int'(bus.ball_run),    e.run);
               chk("serve_pulse", int'(bus.serve_pulse), e.pulse);
               chk("serve_dir",   int'(bus.serve_dir),   e.dir);
               chk("p1_score",    int'(bus.p1_score),    e.p1);
               chk("p2_score",    int'(bus.p2_score),    e.p2);
               chk("winner",      int'(bus.winner),      e.win);
            end
         end
      end
   end

   initial begin
      bit st, sv, r_n;
      bus.frame_tick = 1'b0; bus.start_btn = 1'b1; bus.serve_btn = 1'b0;
      bus.miss_top = 1'b0;   bus.miss_bot = 1'b0;

      // start_btn held high across reset and release must not start a match.
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Directed opening: start, manual serve, bottom miss, pause back to serve.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3 * PF; i++) drive(1'b1, (i % 3) == 0, 1'b1, 1'b1, 1'b0, 1'b0);

      st = 1'b1; sv = 1'b1;
      for (int i = 0; i < N_RANDOM; i++) begin
         if ($urandom_range(0, 29) == 0) st = ~st;
         if ($urandom_range(0, 7) == 0)  sv = ~sv;
         r_n = ($urandom_range(0, 699) != 0);
         drive(r_n, $urandom_range(0, 2) == 0, st, sv,
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end

      @(posedge pixel_clk);
      #2;
      if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
